// File: rtl/fnn_pkg.sv
// fnn_pkg: shared types and geometry for the FNN weight-load path.
// FSM encoding, layer-size defaults, fan-in/word-count helpers, bus offsets.
package fnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } wls_state_e;

  localparam int WEIGHT_WIDTH_DEF  = 16;
  localparam int PART_NO_WIDTH_DEF = 7;
  localparam int NO_INPUTS_DEF     = 784;
  localparam int NN_L1_DEF         = 40;
  localparam int NN_L2_DEF         = 10;
  localparam int NN_L3_DEF         = 10;
  localparam int NN_L4_DEF         = 10;
  localparam int ADDR_WIDTH_DEF    = 15;

  // weight_bus is [0:W+P-1]; weight occupies the low indices
  localparam int WB_WEIGHT_OFS = 0;

  // layer is 0-based here; layer k+1 fans in from layer k's neurons
  function automatic int fan_in_of(
    input int layer,
    input int no_inputs,
    input int nn1,
    input int nn2,
    input int nn3
  );
    case (layer)
      0:       return no_inputs;
      1:       return nn1;
      2:       return nn2;
      default: return nn3;
    endcase
  endfunction

  function automatic int layer_words(
    input int fan_in,
    input int nn
  );
    return fan_in * nn;
  endfunction

endpackage

// File: rtl/wls_skid_buf.sv
// wls_skid_buf: 2-entry valid/ready buffer for {weight, layer, part_no, last}.
// Ports: push/din in, valid/dout/pop_ready out side, flush empties, count = occupancy.
module wls_skid_buf #(
  parameter int DW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop_ready,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign valid = (cnt_q != 2'd0);
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign pop   = valid && pop_ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: streams ROM weights into FNN layers 1..4 over one bus.
// ROM side: rom_rd_en/rom_addr/rom_data. Bus side: weight_bus/weight_valid/
// wb_ready, layer_sel, layer_done. Control: start_load, abort, load_weights,
// load_done, busy. checksum is live only when WLS_CHECKSUM_EN is defined.
module weight_load_sequencer
  import fnn_pkg::*;
#(
  parameter int WEIGHT_WIDTH  = WEIGHT_WIDTH_DEF,
  parameter int PART_NO_WIDTH = PART_NO_WIDTH_DEF,
  parameter int NO_INPUTS     = NO_INPUTS_DEF,
  parameter int NN_L1         = NN_L1_DEF,
  parameter int NN_L2         = NN_L2_DEF,
  parameter int NN_L3         = NN_L3_DEF,
  parameter int NN_L4         = NN_L4_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_load,
  input  logic                    abort,
  output logic                    rom_rd_en,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [WEIGHT_WIDTH-1:0] rom_data,
  output logic [0:WEIGHT_WIDTH+PART_NO_WIDTH-1] weight_bus,
  output logic                    weight_valid,
  input  logic                    wb_ready,
  output logic                    load_weights,
  output logic [3:0]              layer_sel,
  output logic                    layer_done,
  output logic                    load_done,
  output logic                    busy,
  output logic [31:0]             checksum
);

  localparam int W  = WEIGHT_WIDTH;
  localparam int P  = PART_NO_WIDTH;
  localparam int DW = W + 2 + P + 1;
  localparam int FI1 = fan_in_of(0, NO_INPUTS, NN_L1, NN_L2, NN_L3);
  localparam int FI2 = fan_in_of(1, NO_INPUTS, NN_L1, NN_L2, NN_L3);
  localparam int FI3 = fan_in_of(2, NO_INPUTS, NN_L1, NN_L2, NN_L3);
  localparam int FI4 = fan_in_of(3, NO_INPUTS, NN_L1, NN_L2, NN_L3);
  localparam int TOTAL = layer_words(FI1, NN_L1) + layer_words(FI2, NN_L2)
                       + layer_words(FI3, NN_L3) + layer_words(FI4, NN_L4);

  wls_state_e            state_q, state_d;
  logic [1:0]            layer_q, layer_d;
  logic [P-1:0]          neuron_q, neuron_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic [P+2:0]          tag_q, tag_d;

  logic [ADDR_WIDTH-1:0] fan_in;
  logic [P-1:0]          nn;
  logic last_idx, last_nrn, last_lyr, last_all;
  logic fire, xfer, flush, accept;

  logic [1:0]    occ;
  logic          sb_valid;
  logic [DW-1:0] sb_dout;
  logic [W-1:0]  o_w;
  logic [1:0]    o_l;
  logic [P-1:0]  o_p;
  logic          o_last;

  // tag travels with the read: {layer, neuron, last_in_layer}
  wls_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (rd_q && !flush),
    .din       ({rom_data, tag_q}),
    .pop_ready (wb_ready),
    .valid     (sb_valid),
    .dout      (sb_dout),
    .count     (occ)
  );

  assign o_w    = sb_dout[DW-1 -: W];
  assign o_l    = sb_dout[P+2:P+1];
  assign o_p    = sb_dout[P:1];
  assign o_last = sb_dout[0];

  assign xfer   = sb_valid && wb_ready;
  assign accept = (state_q == S_IDLE) && start_load && !abort;

  always_comb begin
    fan_in = ADDR_WIDTH'(FI1);
    nn     = P'(NN_L1);
    case (layer_q)
      2'd0: begin fan_in = ADDR_WIDTH'(FI1); nn = P'(NN_L1); end
      2'd1: begin fan_in = ADDR_WIDTH'(FI2); nn = P'(NN_L2); end
      2'd2: begin fan_in = ADDR_WIDTH'(FI3); nn = P'(NN_L3); end
      default: begin fan_in = ADDR_WIDTH'(FI4); nn = P'(NN_L4); end
    endcase
  end

  assign last_idx = (idx_q == fan_in - 1'b1);
  assign last_nrn = (neuron_q == nn - 1'b1);
  assign last_lyr = last_idx && last_nrn;
  assign last_all = (addr_q == ADDR_WIDTH'(TOTAL - 1));

  // credit check counts this cycle's pop so a full-rate stream keeps
  // one read in flight and one word on the bus
  assign fire = (state_q == S_FETCH)
             && (({1'b0, occ} + {2'b0, rd_q}) < (3'd2 + {2'b0, xfer}));

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    tag_d    = {layer_q, neuron_q, last_lyr};
    flush    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_FETCH;
          layer_d  = 2'd0;
          neuron_d = '0;
          idx_d    = '0;
          addr_d   = '0;
        end
      end
      S_FETCH: begin
        if (fire) begin
          rd_d = 1'b1;
          if (last_all) state_d = S_DRAIN;
          else addr_d = addr_q + 1'b1;
          if (!last_idx) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            if (!last_nrn) begin
              neuron_d = neuron_q + 1'b1;
            end else begin
              neuron_d = '0;
              layer_d  = layer_q + 2'd1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (xfer && o_last && o_l == 2'd3) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      rd_d    = 1'b0;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= 2'd0;
      neuron_q <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    weight_bus = '0;
    if (sb_valid) begin
      weight_bus[WB_WEIGHT_OFS +: W]     = o_w;
      weight_bus[WB_WEIGHT_OFS + W +: P] = o_p;
    end
  end

  assign rom_rd_en    = fire;
  assign rom_addr     = addr_q;
  assign weight_valid = sb_valid;
  assign layer_sel    = sb_valid ? (4'b0001 << o_l) : 4'b0000;
  assign layer_done   = xfer && o_last;
  assign load_weights = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign load_done    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);

`ifdef WLS_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (accept) checksum_d = '0;
    else if (xfer) checksum_d = checksum_q + 32'(signed'(o_w));
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
